// File: rtl/ysyx_24080006_mem_arb.sv
// Shared memory port arbiter between IFU fetch and LSU load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: LSU priority).
module ysyx_24080006_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_we,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam bit TO_EN = (TIMEOUT > 0);

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    RESP
  } state_e;

  state_e              state_q;
  logic                owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wstrb_q;
  logic                ifu_valid_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic                ifu_err_q;
  logic                lsu_valid_q;
  logic [DATA_W-1:0]   lsu_rdata_q;
  logic                lsu_err_q;

  logic                lsu_win;
  logic                ifu_win;
  logic                idle;
  logic                busy;
  logic                to_hit;
  logic                rsp_hit;
  logic                done;
  logic [DATA_W-1:0]   rdata_d;
  logic                err_d;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // On a tie the requester that did not win last time goes first.
  assign lsu_win = lsu_req_valid &&
                   (!ifu_req_valid || last_q == OWN_IFU);
`else
  assign lsu_win = lsu_req_valid;
`endif

  assign ifu_win = ifu_req_valid && !lsu_win;
  assign idle    = (state_q == IDLE) && !reset;
  assign busy    = (state_q == ADDR) || (state_q == WAIT);

  assign ifu_req_ready = idle && ifu_win;
  assign lsu_req_ready = idle && lsu_win;

  assign to_hit  = TO_EN && busy && (cnt_q == CNT_LAST);
  assign rsp_hit = mem_rsp_valid &&
                   ((state_q == WAIT) ||
                    (state_q == ADDR && mem_req_ready));
  assign done    = rsp_hit || to_hit;

  // A real response beats a timeout that expires in the same cycle.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b1;
    if (rsp_hit) begin
      rdata_d = mem_rsp_rdata;
      err_d   = mem_rsp_err;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      ifu_valid_q <= 1'b0;
      ifu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_valid_q <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= OWN_LSU;
`endif
    end else begin
      ifu_valid_q <= 1'b0;
      lsu_valid_q <= 1'b0;
      if (TO_EN && busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (lsu_win || ifu_win) begin
            state_q     <= ADDR;
            mem_valid_q <= 1'b1;
            cnt_q       <= '0;
            owner_q     <= lsu_win;
`ifdef MEM_ARB_RR_EN
            last_q      <= lsu_win;
`endif
            if (lsu_win) begin
              mem_addr_q  <= lsu_req_addr;
              mem_we_q    <= lsu_req_we;
              mem_wdata_q <= lsu_req_wdata;
              mem_wstrb_q <= lsu_req_wstrb;
            end else begin
              mem_addr_q  <= ifu_req_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
            end
          end
        end
        ADDR: begin
          if (done) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
          end else if (mem_req_ready) begin
            state_q     <= WAIT;
            mem_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (done) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (done) begin
        if (owner_q == OWN_LSU) begin
          lsu_valid_q <= 1'b1;
          lsu_rdata_q <= rdata_d;
          lsu_err_q   <= err_d;
        end else begin
          ifu_valid_q <= 1'b1;
          ifu_rdata_q <= rdata_d;
          ifu_err_q   <= err_d;
        end
      end
    end
  end

  assign mem_req_valid = mem_valid_q;
  assign mem_req_addr  = mem_addr_q;
  assign mem_req_we    = mem_we_q;
  assign mem_req_wdata = mem_wdata_q;
  assign mem_req_wstrb = mem_wstrb_q;

  assign ifu_rsp_valid = ifu_valid_q;
  assign ifu_rsp_rdata = ifu_rdata_q;
  assign ifu_rsp_err   = ifu_err_q;
  assign lsu_rsp_valid = lsu_valid_q;
  assign lsu_rsp_rdata = lsu_rdata_q;
  assign lsu_rsp_err   = lsu_err_q;

endmodule

// File: tb/tb_ysyx_24080006_mem_arb.sv
// Directed bench for ysyx_24080006_mem_arb (TIMEOUT=8).
// Expected grant order follows MEM_ARB_RR_EN when defined.
module tb_ysyx_24080006_mem_arb;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int nvec = 0;
  int nerr = 0;

  ysyx_24080006_mem_arb #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr (ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_rdata(ifu_rsp_rdata),
    .ifu_rsp_err  (ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr (lsu_req_addr),
    .lsu_req_we   (lsu_req_we),
    .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err  (lsu_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_we   (mem_req_we),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err  (mem_rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mvld"}, {31'd0, mem_req_valid}, 0);
    chk({tag, ".maddr"}, mem_req_addr, 0);
    chk({tag, ".mwe"}, {31'd0, mem_req_we}, 0);
    chk({tag, ".mwd"}, mem_req_wdata, 0);
    chk({tag, ".mws"}, {28'd0, mem_req_wstrb}, 0);
    chk({tag, ".ivld"}, {31'd0, ifu_rsp_valid}, 0);
    chk({tag, ".ird"}, ifu_rsp_rdata, 0);
    chk({tag, ".lvld"}, {31'd0, lsu_rsp_valid}, 0);
    chk({tag, ".lrd"}, lsu_rsp_rdata, 0);
    chk({tag, ".irdy"}, {31'd0, ifu_req_ready}, 0);
    chk({tag, ".lrdy"}, {31'd0, lsu_req_ready}, 0);
  endtask

  task automatic ifu_read(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] d);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = a;
    #1;
    chk({tag, ".irdy"}, {31'd0, ifu_req_ready}, 1);
    chk({tag, ".lrdy"}, {31'd0, lsu_req_ready}, 0);
    tick();
    ifu_req_valid = 1'b0;
    chk({tag, ".mvld"}, {31'd0, mem_req_valid}, 1);
    chk({tag, ".maddr"}, mem_req_addr, a);
    chk({tag, ".mwe"}, {31'd0, mem_req_we}, 0);
    chk({tag, ".mws"}, {28'd0, mem_req_wstrb}, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({tag, ".mdrop"}, {31'd0, mem_req_valid}, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = d;
    tick();
    mem_rsp_valid = 1'b0;
    chk({tag, ".ivld"}, {31'd0, ifu_rsp_valid}, 1);
    chk({tag, ".ird"}, ifu_rsp_rdata, d);
    chk({tag, ".ierr"}, {31'd0, ifu_rsp_err}, 0);
    chk({tag, ".lvld"}, {31'd0, lsu_rsp_valid}, 0);
    tick();
    chk({tag, ".ione"}, {31'd0, ifu_rsp_valid}, 0);
  endtask

  task automatic contest(input int idx, input bit exp_lsu);
    string tag;
    logic [31:0] d;
    tag = $sformatf("arb%0d", idx);
    d = 32'h0000_0A00 + 32'(idx);
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    chk({tag, ".irdy"}, {31'd0, ifu_req_ready}, {31'd0, !exp_lsu});
    chk({tag, ".lrdy"}, {31'd0, lsu_req_ready}, {31'd0, exp_lsu});
    tick();
    chk({tag, ".maddr"}, mem_req_addr,
        exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
    chk({tag, ".busy"}, {31'd0, lsu_req_ready | ifu_req_ready}, 0);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = d;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk({tag, ".ivld"}, {31'd0, ifu_rsp_valid}, {31'd0, !exp_lsu});
    chk({tag, ".lvld"}, {31'd0, lsu_rsp_valid}, {31'd0, exp_lsu});
    chk({tag, ".rd"}, exp_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, d);
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h0;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = 32'h0000_0200;
    lsu_req_we    = 1'b0;
    lsu_req_wdata = 32'h0;
    lsu_req_wstrb = 4'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    mem_rsp_err   = 1'b0;
    tick();
    tick();
    chk_zero("rst");
    ifu_req_valid = 1'b0;
    reset = 1'b0;
    tick();

    ifu_read("rd", 32'h8000_0000, 32'h1234_5678);

    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b1;
    lsu_req_addr  = 32'h0000_0010;
    lsu_req_wdata = 32'hAABB_CCDD;
    lsu_req_wstrb = 4'hF;
    #1;
    chk("st.lrdy", {31'd0, lsu_req_ready}, 1);
    tick();
    lsu_req_valid = 1'b0;
    lsu_req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("st.mvld", {31'd0, mem_req_valid}, 1);
      chk("st.maddr", mem_req_addr, 32'h0000_0010);
      chk("st.mwe", {31'd0, mem_req_we}, 1);
      chk("st.mwd", mem_req_wdata, 32'hAABB_CCDD);
      chk("st.mws", {28'd0, mem_req_wstrb}, 32'hF);
      mem_req_ready = (i == 3);
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0;
    tick();
    mem_rsp_valid = 1'b0;
    chk("st.lvld", {31'd0, lsu_rsp_valid}, 1);
    chk("st.lerr", {31'd0, lsu_rsp_err}, 0);
    chk("st.ivld", {31'd0, ifu_rsp_valid}, 0);
    tick();
    chk("st.lone", {31'd0, lsu_rsp_valid}, 0);

    lsu_req_we    = 1'b0;
    lsu_req_addr  = 32'h0000_0200;
    lsu_req_wstrb = 4'h0;
    ifu_req_addr  = 32'h0000_0100;
`ifdef MEM_ARB_RR_EN
    contest(0, 1'b0);
    contest(1, 1'b1);
    contest(2, 1'b0);
    contest(3, 1'b1);
`else
    contest(0, 1'b1);
    contest(1, 1'b1);
    contest(2, 1'b1);
    contest(3, 1'b1);
`endif
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();

    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h0000_0040;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0005;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk("same.ivld", {31'd0, ifu_rsp_valid}, 1);
    chk("same.ird", ifu_rsp_rdata, 32'h5);
    tick();

    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h0000_0080;
    tick();
    ifu_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("to.wait", {31'd0, ifu_rsp_valid}, 0);
      chk("to.mvld", {31'd0, mem_req_valid}, 1);
      tick();
    end
    chk("to.ivld", {31'd0, ifu_rsp_valid}, 1);
    chk("to.ierr", {31'd0, ifu_rsp_err}, 1);
    chk("to.ird", ifu_rsp_rdata, 0);
    chk("to.mdrop", {31'd0, mem_req_valid}, 0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("late.ivld", {31'd0, ifu_rsp_valid}, 0);
    chk("late.lvld", {31'd0, lsu_rsp_valid}, 0);
    chk("late.mvld", {31'd0, mem_req_valid}, 0);
    tick();

    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h0000_0300;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw.mdrop", {31'd0, mem_req_valid}, 0);
    reset = 1'b1;
    tick();
    chk_zero("rw");
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_DEAD;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rw.ivld", {31'd0, ifu_rsp_valid}, 0);
    chk("rw.mvld", {31'd0, mem_req_valid}, 0);
    tick();
    chk("rw.ivld2", {31'd0, ifu_rsp_valid}, 0);
    ifu_read("post", 32'h8000_0100, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
